// File: rtl/ppc_types.sv
// Shared constants and helpers for the result-bus blocks.
package ppc_types;

  localparam int GPR_ADDR_WIDTH = 5;
  localparam int GPR_DATA_WIDTH = 32;

  // Next round-robin position after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin arbiter: the first requester found scanning
// pointer, pointer+1, ... (mod N) wins. Shared by the GPR/SPR/CR result buses.
module round_robin_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         request,
  input  logic [$clog2(N)-1:0] pointer,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_index,
  output logic                 any_grant
);

  localparam int IW = $clog2(N);

  // Scan from the farthest offset down to zero so the nearest requester wins last.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_index = '0;
    any_grant   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(pointer) + k;
      if (idx >= N) idx = idx - N;
      if (request[idx]) begin
        grant       = '0;
        grant[idx]  = 1'b1;
        grant_index = IW'(idx);
        any_grant   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpr_result_bus.sv
// GPR result bus: one buffer slot per execution-unit producer, round-robin
// selection, and a registered one-cycle broadcast that doubles as the
// register-file write port.
module gpr_result_bus
  import ppc_types::*;
#(
  parameter int SOURCES     = 3,
  parameter int RS_ID_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      src_valid    [0:SOURCES-1],
  output logic                      src_ready    [0:SOURCES-1],
  input  logic [RS_ID_WIDTH-1:0]    src_rs_id    [0:SOURCES-1],
  input  logic [GPR_ADDR_WIDTH-1:0] src_reg_addr [0:SOURCES-1],
  input  logic [GPR_DATA_WIDTH-1:0] src_result   [0:SOURCES-1],
  input  logic                      flush,
  output logic                      update_gpr_op_valid,
  output logic [RS_ID_WIDTH-1:0]    update_gpr_op_rs_id_out,
  output logic [GPR_DATA_WIDTH-1:0] update_gpr_op_value_out,
  output logic                      gpr_write_enable,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_write_addr,
  output logic [GPR_DATA_WIDTH-1:0] gpr_write_value
);

  localparam int PW = $clog2(SOURCES);

  // RS ID width is a parameter, so the entry type lives here rather than in the package.
  typedef struct packed {
    logic                      valid;
    logic [RS_ID_WIDTH-1:0]    rs_id;
    logic [GPR_ADDR_WIDTH-1:0] addr;
    logic [GPR_DATA_WIDTH-1:0] value;
  } entry_t;

  entry_t        buf_q [SOURCES];
  entry_t        buf_d [SOURCES];
  entry_t        out_q;
  entry_t        out_d;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  logic [SOURCES-1:0] req;
  logic [SOURCES-1:0] grant;
  logic [PW-1:0]      grant_idx;
  logic               any_grant;

  // Requests come only from registered buffer state, keeping src_* off any output path.
  always_comb begin
    req = '0;
    for (int i = 0; i < SOURCES; i++) req[i] = buf_q[i].valid;
  end

  round_robin_arbiter #(.N(SOURCES)) u_arb (
    .request     (req),
    .pointer     (ptr_q),
    .grant       (grant),
    .grant_index (grant_idx),
    .any_grant   (any_grant)
  );

  // A slot can accept when empty or when its current entry is leaving this cycle.
  always_comb begin
    for (int i = 0; i < SOURCES; i++)
      src_ready[i] = rst & ~flush & (~buf_q[i].valid | grant[i]);
  end

  // Next state: flush wins over grant and capture; capture overrides the grant's clear.
  always_comb begin
    buf_d       = buf_q;
    ptr_d       = ptr_q;
    out_d       = out_q;
    out_d.valid = 1'b0;
    if (flush) begin
      for (int i = 0; i < SOURCES; i++) buf_d[i].valid = 1'b0;
      ptr_d = '0;
    end else begin
      if (any_grant) begin
        out_d                  = buf_q[grant_idx];
        buf_d[grant_idx].valid = 1'b0;
        ptr_d                  = PW'(rr_next(int'(grant_idx), SOURCES));
      end
      for (int i = 0; i < SOURCES; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          buf_d[i].valid = 1'b1;
          buf_d[i].rs_id = src_rs_id[i];
          buf_d[i].addr  = src_reg_addr[i];
          buf_d[i].value = src_result[i];
        end
      end
    end
  end

  // State registers; reset drops pending results and the bus immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SOURCES; i++) buf_q[i] <= '0;
      out_q <= '0;
      ptr_q <= '0;
    end else begin
      for (int i = 0; i < SOURCES; i++) buf_q[i] <= buf_d[i];
      out_q <= out_d;
      ptr_q <= ptr_d;
    end
  end

  assign update_gpr_op_valid     = out_q.valid;
  assign update_gpr_op_rs_id_out = out_q.rs_id;
  assign update_gpr_op_value_out = out_q.value;
  assign gpr_write_enable        = out_q.valid;
  assign gpr_write_addr          = out_q.addr;
  assign gpr_write_value         = out_q.value;

endmodule

// File: tb/tb_gpr_result_bus.sv
// Directed bench for gpr_result_bus with hand-computed expectations.
module tb_gpr_result_bus;

  logic        clk;
  logic        rst;
  logic        src_valid    [0:2];
  logic        src_ready    [0:2];
  logic [4:0]  src_rs_id    [0:2];
  logic [4:0]  src_reg_addr [0:2];
  logic [31:0] src_result   [0:2];
  logic        flush;
  logic        update_gpr_op_valid;
  logic [4:0]  update_gpr_op_rs_id_out;
  logic [31:0] update_gpr_op_value_out;
  logic        gpr_write_enable;
  logic [4:0]  gpr_write_addr;
  logic [31:0] gpr_write_value;

  int n_checks = 0;
  int n_fail   = 0;

  gpr_result_bus #(.SOURCES(3), .RS_ID_WIDTH(5)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .src_valid               (src_valid),
    .src_ready               (src_ready),
    .src_rs_id               (src_rs_id),
    .src_reg_addr            (src_reg_addr),
    .src_result              (src_result),
    .flush                   (flush),
    .update_gpr_op_valid     (update_gpr_op_valid),
    .update_gpr_op_rs_id_out (update_gpr_op_rs_id_out),
    .update_gpr_op_value_out (update_gpr_op_value_out),
    .gpr_write_enable        (gpr_write_enable),
    .gpr_write_addr          (gpr_write_addr),
    .gpr_write_value         (gpr_write_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_src();
    for (int i = 0; i < 3; i++) begin
      src_valid[i]    = 1'b0;
      src_rs_id[i]    = '0;
      src_reg_addr[i] = '0;
      src_result[i]   = '0;
    end
  endtask

  task automatic drive(input int s, input logic [4:0] rs, input logic [4:0] addr,
                       input logic [31:0] val);
    src_valid[s]    = 1'b1;
    src_rs_id[s]    = rs;
    src_reg_addr[s] = addr;
    src_result[s]   = val;
  endtask

  task automatic chk_bus(input string tag, input logic v, input logic [4:0] rs);
    chk({tag, "_valid"}, 64'(update_gpr_op_valid), 64'(v));
    chk({tag, "_we"}, 64'(gpr_write_enable), 64'(v));
    if (v) chk({tag, "_rs"}, 64'(update_gpr_op_rs_id_out), 64'(rs));
  endtask

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    clear_src();

    // Reset state
    #3;
    chk_bus("rst", 1'b0, 5'd0);
    chk("rst_value", 64'(update_gpr_op_value_out), 64'h0);
    chk("rst_addr", 64'(gpr_write_addr), 64'h0);
    for (int i = 0; i < 3; i++) chk("rst_ready", 64'(src_ready[i]), 64'h0);
    tick();
    chk("rst_hold_ready", 64'(src_ready[0]), 64'h0);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk("release_ready", 64'(src_ready[i]), 64'h1);

    // Single source: capture, then one-cycle strobe
    drive(0, 5'd3, 5'd7, 32'hDEADBEEF);
    tick();
    src_valid[0] = 1'b0;
    chk_bus("single_lat", 1'b0, 5'd0);
    chk("single_ready_granted", 64'(src_ready[0]), 64'h1);
    tick();
    chk_bus("single", 1'b1, 5'd3);
    chk("single_value", 64'(update_gpr_op_value_out), 64'hDEADBEEF);
    chk("single_wval", 64'(gpr_write_value), 64'hDEADBEEF);
    chk("single_waddr", 64'(gpr_write_addr), 64'd7);
    tick();
    chk_bus("single_end", 1'b0, 5'd0);
    chk("single_hold_value", 64'(update_gpr_op_value_out), 64'hDEADBEEF);

    // Streaming from source 1, rs_id 1..8
    for (int i = 1; i <= 8; i++) begin
      drive(1, 5'(i), 5'(i), 32'h1000 + 32'(i));
      chk("stream_ready", 64'(src_ready[1]), 64'h1);
      tick();
      if (i >= 2) begin
        chk_bus("stream", 1'b1, 5'(i - 1));
        chk("stream_value", 64'(update_gpr_op_value_out), 64'h1000 + 64'(i - 1));
      end
    end
    src_valid[1] = 1'b0;
    tick();
    chk_bus("stream_last", 1'b1, 5'd8);
    tick();
    chk_bus("stream_idle", 1'b0, 5'd0);

    // Flush with buffers 0 and 1 full and a grant pending
    drive(0, 5'd30, 5'd1, 32'h30);
    drive(1, 5'd31, 5'd2, 32'h31);
    tick();
    clear_src();
    flush = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk("flush_ready", 64'(src_ready[i]), 64'h0);
    drive(2, 5'd29, 5'd3, 32'h29);
    tick();
    clear_src();
    flush = 1'b0;
    chk_bus("flush_next", 1'b0, 5'd0);
    #1;
    chk("flush_after_ready", 64'(src_ready[0]), 64'h1);
    tick();
    chk_bus("flush_quiet1", 1'b0, 5'd0);
    tick();
    chk_bus("flush_quiet2", 1'b0, 5'd0);

    // Contention: pointer back at 0, so 10,11,12,10,...
    drive(0, 5'd10, 5'd10, 32'hA0);
    drive(1, 5'd11, 5'd11, 32'hA1);
    drive(2, 5'd12, 5'd12, 32'hA2);
    tick();
    chk_bus("cont_lat", 1'b0, 5'd0);
    chk("cont_ready0", 64'(src_ready[0]), 64'h1);
    chk("cont_ready1", 64'(src_ready[1]), 64'h0);
    chk("cont_ready2", 64'(src_ready[2]), 64'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_bus("cont", 1'b1, 5'(10 + (k % 3)));
    end
    clear_src();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_bus("cont_drain", 1'b1, 5'(10 + k));
    end
    tick();
    chk_bus("cont_idle", 1'b0, 5'd0);

    // Grant and recapture on source 2 in the same cycle
    drive(2, 5'd19, 5'd4, 32'h19);
    tick();
    drive(2, 5'd20, 5'd5, 32'h20);
    #1;
    chk("recap_ready", 64'(src_ready[2]), 64'h1);
    tick();
    clear_src();
    chk_bus("recap_old", 1'b1, 5'd19);
    chk("recap_old_value", 64'(update_gpr_op_value_out), 64'h19);
    tick();
    chk_bus("recap_new", 1'b1, 5'd20);
    chk("recap_new_addr", 64'(gpr_write_addr), 64'd5);
    tick();
    chk_bus("recap_idle", 1'b0, 5'd0);

    // Asynchronous reset mid-stream
    drive(0, 5'd5, 5'd6, 32'h55);
    tick();
    drive(0, 5'd6, 5'd6, 32'h66);
    tick();
    chk_bus("arst_pre", 1'b1, 5'd5);
    #2;
    rst = 1'b0;
    #1;
    chk_bus("arst", 1'b0, 5'd0);
    chk("arst_rs", 64'(update_gpr_op_rs_id_out), 64'h0);
    chk("arst_value", 64'(update_gpr_op_value_out), 64'h0);
    chk("arst_addr", 64'(gpr_write_addr), 64'h0);
    for (int i = 0; i < 3; i++) chk("arst_ready", 64'(src_ready[i]), 64'h0);
    #1;
    rst = 1'b1;
    drive(0, 5'd7, 5'd9, 32'h77);
    #1;
    chk("arst_release_ready", 64'(src_ready[0]), 64'h1);
    tick();
    clear_src();
    chk_bus("arst_lat", 1'b0, 5'd0);
    tick();
    chk_bus("arst_after", 1'b1, 5'd7);
    chk("arst_after_addr", 64'(gpr_write_addr), 64'd9);
    chk("arst_after_value", 64'(gpr_write_value), 64'h77);
    tick();
    chk_bus("arst_idle", 1'b0, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_result_bus.md
Name: gpr_result_bus

Overview:
- Consumer end of the GPR result ready-valid channels produced by execution units (ALU, load/store, system unit).
- Accepts results from SOURCES producers, buffers one result per source, and arbitrates round-robin.
- Drives the winner as a one-cycle broadcast on the GPR operand-update bus (update_gpr_op_valid / rs_id / value) for all reservation stations, and as a GPR register-file write.

Parameters:
- SOURCES, 3, number of result producers (>=2).
- RS_ID_WIDTH, 5, width of reservation-station IDs.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- src_valid  in  1 [0:SOURCES-1]  producer result valid.
- src_ready  out  1 [0:SOURCES-1]  result accepted.
- src_rs_id  in  RS_ID_WIDTH [0:SOURCES-1]  producing RS ID.
- src_reg_addr  in  5 [0:SOURCES-1]  destination GPR.
- src_result  in  32 [0:SOURCES-1]  result value.
- flush  in  1  synchronous discard of all pending results.
- update_gpr_op_valid  out  1  broadcast strobe, one cycle per result.
- update_gpr_op_rs_id_out  out  RS_ID_WIDTH  broadcast RS ID.
- update_gpr_op_value_out  out  32  broadcast value.
- gpr_write_enable  out  1  register-file write strobe; equals update_gpr_op_valid.
- gpr_write_addr  out  5  register-file write address.
- gpr_write_value  out  32  register-file write data.

Behaviour:
- Reset (rst=0, asynchronous):
  - All buffer valids=0, rr_ptr=0.
  - All broadcast/write outputs=0.
  - src_ready forced to 0 while rst=0.
- Per-source buffer: one entry {valid, rs_id, reg_addr, value}.
  - Capture when src_valid[i] & src_ready[i] at an edge.
- Grant:
  - Computed combinationally from registered state only: buf_valid and rr_ptr.
  - Winner is the first valid buffer scanning rr_ptr, rr_ptr+1, ... modulo SOURCES.
  - At most one grant per cycle.
- src_ready[i] = rst & (!buf_valid[i] | grant[i]). No combinational path from any src_* input to any output.
- On an edge with a grant g:
  - Output register loads buffer g. Valid outputs=1 in the following cycle.
  - buf_valid[g] cleared, unless simultaneously recaptured, in which case the new data replaces it.
  - rr_ptr <= (g+1) mod SOURCES; wrap from SOURCES-1 to 0.
- No grant: valid outputs=0 next cycle; data outputs hold their last values; rr_ptr unchanged.
- Latency: result accepted at edge k appears on the bus in cycle after edge k+1 at the earliest.
- Throughput: one result per cycle total. A single active source sustains 1/cycle.
- No backpressure from the bus; each strobe is exactly one cycle. Consumers must sample it.
- Fairness: with all sources continuously valid, grants rotate 0,1,2,0,... Each source waits at most SOURCES-1 cycles after its buffer fills.
- flush=1 at an edge:
  - All buf_valid cleared and valid outputs cleared next cycle.
  - src_ready=0 during flush; no capture. rr_ptr reset to 0.
  - flush takes priority over grant and capture.
- Reset asserted mid-operation: pending results are lost and outputs drop immediately (asynchronous).
- Reset deassertion takes effect at the next edge; src_ready rises combinationally once rst=1.

Decomposition:
- ppc_types gains the constant GPR_ADDR_WIDTH=5.
- Because RS_ID_WIDTH is a parameter, the buffer entry struct stays local to the module.
- One sub-module: round_robin_arbiter.
  - Parameter N.
  - Inputs: request[0:N-1], pointer.
  - Outputs: grant one-hot, grant_index, any_grant.
  - Reusable for the SPR and CR result buses.

Test Plan:
- Single source: src 0 valid with rs_id=3, addr=7, value=0xDEADBEEF at edge 1 -> edge 2 grants; update_gpr_op_valid=1 for exactly one cycle after edge 2 with rs_id=3, value=0xDEADBEEF; gpr_write_addr=7.
- Streaming: src 1 valid every cycle with rs_id 1..8 -> src_ready stays 1, 8 consecutive strobes in order, no gaps.
- Contention: all 3 sources held valid, rs_ids 10/11/12 -> broadcast order 10,11,12,10,...; rr_ptr wraps 2->0; no source starves.
- Simultaneous grant and recapture: src 2 buffer granted while src 2 presents rs_id=20 -> old result broadcast, rs_id=20 buffered, broadcast next cycle.
- Flush: buffers 0 and 1 full, flush=1 -> no strobe next cycle, src_ready=0 during flush, rr_ptr=0, nothing emitted afterward.
- Async reset mid-stream: rst=0 between edges -> outputs and src_ready go 0 immediately; after release, first new result is broadcast normally.
